// File: rtl/alu_nbit.sv
// Registered WIDTH-bit ALU: add/sub/inc/dec, xor/or/and, arithmetic shift right by one.
// Optional zero/overflow flags are compiled in when ALU_FLAGS_EN is defined.
module alu_nbit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH:0]   result,
    output logic             out_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero_flag,
    output logic             ovf_flag
`endif
);

    logic [WIDTH-1:0] w_m;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_logic;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_next;

    logic [WIDTH:0]   r_result;
    logic             r_out_valid;

    // Second adder operand and carry-in derived from op[1:0].
    always_comb begin
        w_m = b;
        unique case (op[1:0])
            2'b00:   w_m = b;
            2'b01:   w_m = ~b;
            2'b10:   w_m = '0;
            default: w_m = '1;
        endcase
        w_cin = op[1] ^ op[0];
    end

    assign w_sum = {1'b0, a} + {1'b0, w_m} + {{WIDTH{1'b0}}, w_cin};

    always_comb begin
        w_logic = '0;
        if (!op[1]) begin
            w_logic[WIDTH-1:0] = a ^ b;
        end else if (!op[0]) begin
            w_logic[WIDTH-1:0] = a | b;
        end else begin
            w_logic[WIDTH-1:0] = a & b;
        end
    end

    assign w_shift = {a[WIDTH-1], a[WIDTH-1], a[WIDTH-1:1]};

    always_comb begin
        w_next = w_sum;
        if (op[3]) begin
            w_next = w_shift;
        end else if (op[2]) begin
            w_next = w_logic;
        end else begin
            w_next = w_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_next;
            end
        end
    end

    assign result    = r_result;
    assign out_valid = r_out_valid;

`ifdef ALU_FLAGS_EN
    logic w_zero;
    logic w_ovf;
    logic r_zero;
    logic r_ovf;

    assign w_zero = (w_next[WIDTH-1:0] == '0);
    // Overflow only for the arithmetic class: like-signed operands, differently signed sum.
    assign w_ovf  = (op[3:2] == 2'b00) && (a[WIDTH-1] == w_m[WIDTH-1])
                    && (w_sum[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (in_valid) begin
            r_zero <= w_zero;
            r_ovf  <= w_ovf;
        end
    end

    assign zero_flag = r_zero;
    assign ovf_flag  = r_ovf;
`endif

endmodule

// File: tb/tb_alu_nbit.sv
// Self-checking bench for alu_nbit (WIDTH=4): directed vector table plus hold and async-reset sequences.
module tb_alu_nbit;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic [WIDTH:0]   result;
    logic             out_valid;
`ifdef ALU_FLAGS_EN
    logic             zero_flag;
    logic             ovf_flag;
`endif

    int checks;
    int failures;

    alu_nbit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .result    (result),
        .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
        ,
        .zero_flag (zero_flag),
        .ovf_flag  (ovf_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic [4:0] exp;
        logic       exp_z;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    initial begin
        logic [4:0] held;
        checks   = 0;
        failures = 0;

        vecs[0]  = '{4'b0110, 4'b0111, 4'b0000, 5'b01101, 1'b0, 1'b1};
        vecs[1]  = '{4'b0110, 4'b0111, 4'b0001, 5'b01111, 1'b0, 1'b0};
        vecs[2]  = '{4'b1111, 4'b0000, 4'b0010, 5'b10000, 1'b1, 1'b0};
        vecs[3]  = '{4'b0000, 4'b0000, 4'b0011, 5'b01111, 1'b0, 1'b0};
        vecs[4]  = '{4'b0101, 4'b0000, 4'b0011, 5'b10100, 1'b0, 1'b0};
        vecs[5]  = '{4'b1100, 4'b1010, 4'b0100, 5'b00110, 1'b0, 1'b0};
        vecs[6]  = '{4'b1100, 4'b1010, 4'b0110, 5'b01110, 1'b0, 1'b0};
        vecs[7]  = '{4'b1100, 4'b1010, 4'b0111, 5'b01000, 1'b0, 1'b0};
        vecs[8]  = '{4'b1100, 4'b1010, 4'b0101, 5'b00110, 1'b0, 1'b0};
        vecs[9]  = '{4'b1010, 4'b0101, 4'b1000, 5'b11101, 1'b0, 1'b0};
        vecs[10] = '{4'b1010, 4'b1000, 4'b1111, 5'b11101, 1'b0, 1'b0};
        vecs[11] = '{4'b0110, 4'b1111, 4'b1000, 5'b00011, 1'b0, 1'b0};
        vecs[12] = '{4'b0110, 4'b0000, 4'b1011, 5'b00011, 1'b0, 1'b0};
        vecs[13] = '{4'b0111, 4'b0001, 4'b0000, 5'b01000, 1'b0, 1'b1};
        vecs[14] = '{4'b0101, 4'b0101, 4'b0001, 5'b10000, 1'b1, 1'b0};
        vecs[15] = '{4'b1000, 4'b1000, 4'b0000, 5'b10000, 1'b1, 1'b1};
        vecs[16] = '{4'b0001, 4'b0110, 4'b1000, 5'b00000, 1'b1, 1'b0};
        vecs[17] = '{4'b1000, 4'b0001, 4'b0001, 5'b10111, 1'b0, 1'b1};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        op       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", 32'(result), 32'h0);
        check("reset_valid", 32'(out_valid), 32'h0);
`ifdef ALU_FLAGS_EN
        check("reset_zero", 32'(zero_flag), 32'h0);
        check("reset_ovf", 32'(ovf_flag), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            a        = vecs[i].a;
            b        = vecs[i].b;
            op       = vecs[i].op;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].exp));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'h1);
`ifdef ALU_FLAGS_EN
            check($sformatf("vec%0d_zero", i), 32'(zero_flag), 32'(vecs[i].exp_z));
            check($sformatf("vec%0d_ovf", i), 32'(ovf_flag), 32'(vecs[i].exp_ovf));
`endif
        end

        // Idle cycles with changing operands: result must hold.
        held = vecs[17].exp;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a        = 4'(i + 3);
            b        = 4'(i);
            op       = 4'b0000;
            @(posedge clk);
            #1;
            check($sformatf("idle%0d_valid", i), 32'(out_valid), 32'h0);
            check($sformatf("idle%0d_result", i), 32'(result), 32'(held));
        end

        // Load a nonzero result, then assert reset between edges.
        @(negedge clk);
        a        = 4'b0110;
        b        = 4'b0111;
        op       = 4'b0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("prereset_result", 32'(result), 32'h0d);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_result", 32'(result), 32'h0);
        check("async_reset_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        check("held_reset_result", 32'(result), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_result", 32'(result), 32'h0d);
        check("post_reset_valid", 32'(out_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
